// File: rtl/csr_pkg.sv
// csr_pkg: shared encodings for the CSR read-modify-write controller.
// Holds the access op codes, the sequencer state encoding and the
// read-only address-field constant used by csr_rmw_ctrl and its bench.
package csr_pkg;

  localparam int CSR_ADDR_W = 12;

  // addr[11:10] == 2'b11 marks a read-only CSR.
  localparam logic [1:0] CSR_RO_FIELD = 2'b11;

  typedef enum logic [1:0] {
    OP_READ = 2'b00,
    OP_RW   = 2'b01,
    OP_RS   = 2'b10,
    OP_RC   = 2'b11
  } csr_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } csr_state_e;

  // RW always writes; RS/RC write only when the mask has a bit set.
  function automatic logic csr_write_intended(csr_op_e op, logic mask_nz);
    return (op == OP_RW) || (((op == OP_RS) || (op == OP_RC)) && mask_nz);
  endfunction

endpackage

// File: rtl/csr_rr_arbiter.sv
// csr_rr_arbiter: 2-way round-robin arbiter with a one-hot grant.
// Index 0 is the pipeline requester, index 1 the debug requester.
// The grant is combinational; the last-grant memory only moves on advance_i.
module csr_rr_arbiter (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic r_last_dbg;

  // Lone request wins outright; on a tie the requester not served last wins.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves gnt_o unassigned (which would infer a latch).
    gnt_o = 2'b00;
    if (req_i[0] && req_i[1]) begin
      gnt_o = r_last_dbg ? 2'b01 : 2'b10;
    end else if (req_i[0]) begin
      gnt_o = 2'b01;
    end else if (req_i[1]) begin
      gnt_o = 2'b10;
    end
  end

  // Remember who was served; resets to pipeline so debug wins the first tie.
  always_ff @(posedge clk_i or posedge reset_i) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (reset_i) begin
      r_last_dbg <= 1'b0;
    end else if (advance_i) begin
      r_last_dbg <= gnt_o[1];
    end
  end

endmodule

// File: rtl/csr_rmw_ctrl.sv
// csr_rmw_ctrl: arbitrates a pipeline and a debug requester onto a CSR file
// and performs READ / RW / RS / RC as a fixed IDLE -> RD -> WR -> RESP sequence.
// Optional feature macro: CSR_RMW_DEBUG_PORT_EN. When undefined the debug
// ports stay present, dbg_req_i is ignored and dbg_done_o/dbg_illegal_o are 0.
module csr_rmw_ctrl
  import csr_pkg::*;
#(
  parameter int C_XLEN = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clk_en_i,
  input  logic                  pl_req_i,
  input  logic [1:0]            pl_op_i,
  input  logic [CSR_ADDR_W-1:0] pl_addr_i,
  input  logic [C_XLEN-1:0]     pl_wdata_i,
  input  logic                  dbg_req_i,
  input  logic [1:0]            dbg_op_i,
  input  logic [CSR_ADDR_W-1:0] dbg_addr_i,
  input  logic [C_XLEN-1:0]     dbg_wdata_i,
  output logic                  pl_done_o,
  output logic                  dbg_done_o,
  output logic                  pl_illegal_o,
  output logic                  dbg_illegal_o,
  output logic [C_XLEN-1:0]     rdata_o,
  output logic                  csr_access_o,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_addr_o,
  output logic [C_XLEN-1:0]     csr_wdata_o,
  input  logic [C_XLEN-1:0]     csr_rdata_i,
  input  logic                  csr_illegal_i
);

  csr_state_e            r_state;
  logic                  r_gnt_dbg;
  csr_op_e               r_op;
  logic [CSR_ADDR_W-1:0] r_addr;
  logic [C_XLEN-1:0]     r_wdata;
  logic [C_XLEN-1:0]     r_old;
  logic                  r_illegal;

  logic                  r_csr_access;
  logic                  r_csr_we;
  logic [CSR_ADDR_W-1:0] r_csr_addr;
  logic [C_XLEN-1:0]     r_csr_wdata;
  logic                  r_pl_done;
  logic                  r_dbg_done;
  logic                  r_pl_illegal;
  logic                  r_dbg_illegal;
  logic [C_XLEN-1:0]     r_rdata;

  logic                  w_dbg_req;
  logic [1:0]            w_gnt;
  logic                  w_advance;
  csr_op_e               w_sel_op;
  logic [CSR_ADDR_W-1:0] w_sel_addr;
  logic [C_XLEN-1:0]     w_sel_wdata;
  logic                  w_wr_intent;
  logic                  w_illegal;
  logic [C_XLEN-1:0]     w_new;

`ifdef CSR_RMW_DEBUG_PORT_EN
  assign w_dbg_req = dbg_req_i;
`else
  assign w_dbg_req = 1'b0;
`endif

  // Only advance the round-robin pointer when a grant is actually taken.
  assign w_advance = clk_en_i && (r_state == ST_IDLE) && (|w_gnt);

  csr_rr_arbiter u_arb (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .req_i     ({w_dbg_req, pl_req_i}),
    .advance_i (w_advance),
    .gnt_o     (w_gnt)
  );

  assign w_sel_op    = csr_op_e'(w_gnt[1] ? dbg_op_i : pl_op_i);
  assign w_sel_addr  = w_gnt[1] ? dbg_addr_i : pl_addr_i;
  assign w_sel_wdata = w_gnt[1] ? dbg_wdata_i : pl_wdata_i;

  assign w_wr_intent = csr_write_intended(r_op, |r_wdata);
  assign w_illegal   = csr_illegal_i ||
                       (w_wr_intent && (r_addr[11:10] == CSR_RO_FIELD));

  // New CSR value built from the old value presented during RD.
  always_comb begin
    w_new = r_wdata;
    case (r_op)
      OP_RS:   w_new = csr_rdata_i | r_wdata;
      OP_RC:   w_new = csr_rdata_i & ~r_wdata;
      default: w_new = r_wdata;
    endcase
  end

  // Sequencer: one state per enabled cycle, all outputs registered.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ST_IDLE;
      r_gnt_dbg     <= 1'b0;
      r_op          <= OP_READ;
      r_addr        <= '0;
      r_wdata       <= '0;
      r_old         <= '0;
      r_illegal     <= 1'b0;
      r_csr_access  <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= '0;
      r_csr_wdata   <= '0;
      r_pl_done     <= 1'b0;
      r_dbg_done    <= 1'b0;
      r_pl_illegal  <= 1'b0;
      r_dbg_illegal <= 1'b0;
      r_rdata       <= '0;
    end else if (clk_en_i) begin
      // Strobes and completion outputs are single-cycle unless re-asserted below.
      r_csr_access  <= 1'b0;
      r_csr_we      <= 1'b0;
      r_csr_addr    <= '0;
      r_csr_wdata   <= '0;
      r_pl_done     <= 1'b0;
      r_dbg_done    <= 1'b0;
      r_pl_illegal  <= 1'b0;
      r_dbg_illegal <= 1'b0;
      r_rdata       <= '0;
      case (r_state)
        ST_IDLE: begin
          if (|w_gnt) begin
            r_gnt_dbg    <= w_gnt[1];
            r_op         <= w_sel_op;
            r_addr       <= w_sel_addr;
            r_wdata      <= w_sel_wdata;
            r_csr_access <= 1'b1;
            r_csr_addr   <= w_sel_addr;
            r_state      <= ST_RD;
          end
        end
        ST_RD: begin
          r_old     <= csr_rdata_i;
          r_illegal <= w_illegal;
          if (w_wr_intent && !w_illegal) begin
            r_csr_access <= 1'b1;
            r_csr_we     <= 1'b1;
            r_csr_addr   <= r_addr;
            r_csr_wdata  <= w_new;
          end
          r_state <= ST_WR;
        end
        ST_WR: begin
          r_pl_done     <= !r_gnt_dbg;
          r_dbg_done    <= r_gnt_dbg;
          r_pl_illegal  <= !r_gnt_dbg && r_illegal;
          r_dbg_illegal <= r_gnt_dbg && r_illegal;
          r_rdata       <= r_illegal ? '0 : r_old;
          r_state       <= ST_RESP;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign csr_access_o = r_csr_access;
  assign csr_we_o     = r_csr_we;
  assign csr_addr_o   = r_csr_addr;
  assign csr_wdata_o  = r_csr_wdata;
  assign rdata_o      = r_rdata;
  assign pl_done_o    = r_pl_done;
  assign pl_illegal_o = r_pl_illegal;

`ifdef CSR_RMW_DEBUG_PORT_EN
  assign dbg_done_o    = r_dbg_done;
  assign dbg_illegal_o = r_dbg_illegal;
`else
  // Debug completion registers never set here; keep them visibly sunk.
  logic w_unused_dbg;
  assign w_unused_dbg  = dbg_req_i ^ r_dbg_done ^ r_dbg_illegal;
  assign dbg_done_o    = 1'b0;
  assign dbg_illegal_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_rmw_ctrl.sv
// tb_csr_rmw_ctrl: self-checking bench for csr_rmw_ctrl.
// A behavioural CSR file answers the DUT; a reference copy of the CSR
// contents plus an expectation queue predict every completion.
`timescale 1ns/1ps
module tb_csr_rmw_ctrl;
  import csr_pkg::*;

  localparam int          XLEN     = 32;
  localparam logic [11:0] ILL_ADDR = 12'h7FF;

  logic            clk_i = 1'b0;
  logic            reset_i;
  logic            clk_en_i;
  logic            pl_req_i, dbg_req_i;
  logic [1:0]      pl_op_i, dbg_op_i;
  logic [11:0]     pl_addr_i, dbg_addr_i;
  logic [XLEN-1:0] pl_wdata_i, dbg_wdata_i;
  logic            pl_done_o, dbg_done_o, pl_illegal_o, dbg_illegal_o;
  logic [XLEN-1:0] rdata_o;
  logic            csr_access_o, csr_we_o;
  logic [11:0]     csr_addr_o;
  logic [XLEN-1:0] csr_wdata_o, csr_rdata_i;
  logic            csr_illegal_i;

  typedef struct {
    logic            dbg;
    logic            illegal;
    logic [XLEN-1:0] rdata;
    logic            wr;
  } exp_t;

  exp_t            exp_q[$];
  logic [XLEN-1:0] csr_mem [0:4095];
  logic [XLEN-1:0] ref_mem [0:4095];
  int              checks = 0;
  int              failures = 0;
  int              wr_cnt = 0;
  int              pl_done_cnt = 0;
  int              dbg_done_cnt = 0;

  csr_rmw_ctrl #(.C_XLEN(XLEN)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .clk_en_i      (clk_en_i),
    .pl_req_i      (pl_req_i),
    .pl_op_i       (pl_op_i),
    .pl_addr_i     (pl_addr_i),
    .pl_wdata_i    (pl_wdata_i),
    .dbg_req_i     (dbg_req_i),
    .dbg_op_i      (dbg_op_i),
    .dbg_addr_i    (dbg_addr_i),
    .dbg_wdata_i   (dbg_wdata_i),
    .pl_done_o     (pl_done_o),
    .dbg_done_o    (dbg_done_o),
    .pl_illegal_o  (pl_illegal_o),
    .dbg_illegal_o (dbg_illegal_o),
    .rdata_o       (rdata_o),
    .csr_access_o  (csr_access_o),
    .csr_we_o      (csr_we_o),
    .csr_addr_o    (csr_addr_o),
    .csr_wdata_o   (csr_wdata_o),
    .csr_rdata_i   (csr_rdata_i),
    .csr_illegal_i (csr_illegal_i)
  );

  always #5 clk_i = ~clk_i;

  // Behavioural CSR file: 0x7FF does not exist.
  assign csr_rdata_i   = csr_mem[csr_addr_o];
  assign csr_illegal_i = csr_access_o && (csr_addr_o == ILL_ADDR);

  always @(posedge clk_i) begin
    if (!reset_i && clk_en_i && csr_access_o && csr_we_o) begin
      csr_mem[csr_addr_o] = csr_wdata_o;
      wr_cnt++;
    end
  end

  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (pl_done_o)  pl_done_cnt++;
      if (dbg_done_o) dbg_done_cnt++;
    end
  end

  // Reference model of one access.
  function automatic exp_t model(logic is_dbg, logic [1:0] op, logic [11:0] addr,
                                 logic [XLEN-1:0] wdata, logic [XLEN-1:0] old);
    exp_t e;
    logic intent;
    intent    = (op == 2'b01) || ((op[1] == 1'b1) && (wdata != '0));
    e.dbg     = is_dbg;
    e.illegal = (addr == ILL_ADDR) || (intent && (addr[11:10] == 2'b11));
    e.rdata   = e.illegal ? '0 : old;
    e.wr      = intent && !e.illegal;
    return e;
  endfunction

  function automatic logic [XLEN-1:0] new_val(logic [1:0] op, logic [XLEN-1:0] wdata,
                                              logic [XLEN-1:0] old);
    if (op == 2'b01) return wdata;
    if (op == 2'b10) return old | wdata;
    return old & ~wdata;
  endfunction

  task automatic drive_req(input logic is_dbg, input logic req, input logic [1:0] op,
                           input logic [11:0] addr, input logic [XLEN-1:0] wdata);
    if (is_dbg) begin
      dbg_req_i = req; dbg_op_i = op; dbg_addr_i = addr; dbg_wdata_i = wdata;
    end else begin
      pl_req_i = req; pl_op_i = op; pl_addr_i = addr; pl_wdata_i = wdata;
    end
  endtask

  // One access from one requester, optionally stalling clk_en_i in RD.
  task automatic run_single(input string name, input logic is_dbg, input logic [1:0] op,
                            input logic [11:0] addr, input logic [XLEN-1:0] wdata,
                            input int stall);
    exp_t e;
    int   lat;
    int   wr0;
    bit   seen;
    e = model(is_dbg, op, addr, wdata, ref_mem[addr]);
    if (e.wr) ref_mem[addr] = new_val(op, wdata, ref_mem[addr]);
    exp_q.push_back(e);
    wr0  = wr_cnt;
    lat  = 0;
    seen = 0;
    drive_req(is_dbg, 1'b1, op, addr, wdata);
    while (!seen && lat < 30) begin
      @(negedge clk_i);
      lat++;
      if (lat == 1 && stall > 0) begin
        clk_en_i = 1'b0;
        repeat (stall) @(negedge clk_i);
        lat += stall;
        checks++;
        if ({csr_access_o, csr_we_o, csr_addr_o} !== {1'b1, 1'b0, addr}) begin
          $display("FAIL %s stall_hold: access/we/addr=%b/%b/%h need 1/0/%h",
                   name, csr_access_o, csr_we_o, csr_addr_o, addr);
          failures++;
        end
        clk_en_i = 1'b1;
      end
      if (pl_done_o || dbg_done_o) seen = 1;
    end
    drive_req(is_dbg, 1'b0, op, addr, wdata);
    e = exp_q.pop_front();
    checks++;
    if (!seen) begin
      $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      failures++;
    end else begin
      checks += 4;
      if (lat !== 3 + stall) begin
        $display("FAIL %s latency: got %0d need %0d", name, lat, 3 + stall);
        failures++;
      end
      if ({dbg_done_o, pl_done_o} !== {e.dbg, !e.dbg}) begin
        $display("FAIL %s done_port: dbg/pl=%b/%b need %b/%b",
                 name, dbg_done_o, pl_done_o, e.dbg, !e.dbg);
        failures++;
      end
      if (rdata_o !== e.rdata) begin
        $display("FAIL %s rdata: got %h need %h", name, rdata_o, e.rdata);
        failures++;
      end
      if ({dbg_illegal_o, pl_illegal_o} !== (e.dbg ? {e.illegal, 1'b0} : {1'b0, e.illegal})) begin
        $display("FAIL %s illegal: dbg/pl=%b/%b need %b on %s",
                 name, dbg_illegal_o, pl_illegal_o, e.illegal, e.dbg ? "dbg" : "pl");
        failures++;
      end
    end
    checks += 2;
    if (wr_cnt - wr0 !== (e.wr ? 1 : 0)) begin
      $display("FAIL %s write_count: got %0d need %0d", name, wr_cnt - wr0, e.wr ? 1 : 0);
      failures++;
    end
    if (csr_mem[addr] !== ref_mem[addr]) begin
      $display("FAIL %s csr_value: got %h need %h", name, csr_mem[addr], ref_mem[addr]);
      failures++;
    end
    @(negedge clk_i);
    checks++;
    if ({pl_done_o, dbg_done_o} !== 2'b00) begin
      $display("FAIL %s done_width: done still high one cycle later", name);
      failures++;
    end
  endtask

  task automatic test_reset();
    reset_i  = 1'b1;
    clk_en_i = 1'b1;
    drive_req(1'b0, 1'b0, 2'b00, '0, '0);
    drive_req(1'b1, 1'b0, 2'b00, '0, '0);
    repeat (3) @(negedge clk_i);
    checks++;
    if ({csr_access_o, csr_we_o, csr_addr_o, csr_wdata_o, rdata_o,
         pl_done_o, dbg_done_o, pl_illegal_o, dbg_illegal_o} !== '0) begin
      $display("FAIL reset_outputs: access=%b we=%b addr=%h wdata=%h rdata=%h need all 0",
               csr_access_o, csr_we_o, csr_addr_o, csr_wdata_o, rdata_o);
      failures++;
    end
    reset_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if ({csr_access_o, pl_done_o, dbg_done_o} !== 3'b000) begin
      $display("FAIL idle_no_req: access/pl_done/dbg_done=%b/%b/%b need 000",
               csr_access_o, pl_done_o, dbg_done_o);
      failures++;
    end
  endtask

  // Both requesters held high: grant order and 4-cycle spacing.
  task automatic test_back_to_back();
    exp_t e;
    logic exp_dbg;
    int   n_done = 0;
    int   cyc = 0;
    int   dd0;
    dd0 = dbg_done_cnt;
    for (int k = 0; k < 6; k++) begin
`ifdef CSR_RMW_DEBUG_PORT_EN
      exp_dbg = (k % 2 == 0);
`else
      exp_dbg = 1'b0;
`endif
      exp_q.push_back(model(exp_dbg, 2'b00, exp_dbg ? 12'h300 : 12'h340, '0,
                            ref_mem[exp_dbg ? 12'h300 : 12'h340]));
    end
    drive_req(1'b0, 1'b1, 2'b00, 12'h340, '0);
    drive_req(1'b1, 1'b1, 2'b00, 12'h300, '0);
    while (n_done < 6 && cyc < 80) begin
      @(negedge clk_i);
      cyc++;
      if (pl_done_o || dbg_done_o) begin
        e = exp_q.pop_front();
        checks += 3;
        if ({dbg_done_o, pl_done_o} !== {e.dbg, !e.dbg}) begin
          $display("FAIL b2b_grant[%0d]: dbg/pl done=%b/%b need %b/%b",
                   n_done, dbg_done_o, pl_done_o, e.dbg, !e.dbg);
          failures++;
        end
        if (rdata_o !== e.rdata) begin
          $display("FAIL b2b_rdata[%0d]: got %h need %h", n_done, rdata_o, e.rdata);
          failures++;
        end
        if (cyc !== 3 + 4 * n_done) begin
          $display("FAIL b2b_timing[%0d]: done at cycle %0d need %0d", n_done, cyc, 3 + 4 * n_done);
          failures++;
        end
        n_done++;
        if (n_done == 6) begin
          drive_req(1'b0, 1'b0, 2'b00, '0, '0);
          drive_req(1'b1, 1'b0, 2'b00, '0, '0);
        end
      end
    end
    checks++;
    if (n_done != 6) begin
      $display("FAIL b2b_timeout: %0d of 6 completions seen", n_done);
      failures++;
      drive_req(1'b0, 1'b0, 2'b00, '0, '0);
      drive_req(1'b1, 1'b0, 2'b00, '0, '0);
      exp_q.delete();
    end
`ifndef CSR_RMW_DEBUG_PORT_EN
    checks++;
    if (dbg_done_cnt != dd0) begin
      $display("FAIL b2b_dbg_served: %0d debug completions need 0", dbg_done_cnt - dd0);
      failures++;
    end
`endif
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_rmw_ops();
    run_single("rw_340",       1'b0, 2'b01, 12'h340, 32'hA5A5_0000, 0);
    run_single("rs_mask0",     1'b0, 2'b10, 12'h300, 32'h0000_0000, 0);
    run_single("rc_0f",        1'b0, 2'b11, 12'h305, 32'h0000_000F, 0);
    run_single("rw_ro",        1'b0, 2'b01, 12'hC00, 32'h1111_2222, 0);
    run_single("read_ro",      1'b0, 2'b00, 12'hC00, 32'hFFFF_FFFF, 0);
    run_single("rc_ro_mask0",  1'b0, 2'b11, 12'hC00, 32'h0000_0000, 0);
    run_single("rs_set",       1'b0, 2'b10, 12'h300, 32'h0001_0000, 0);
    run_single("rs_nonexist",  1'b0, 2'b10, ILL_ADDR, 32'h0000_0001, 0);
    run_single("read_340",     1'b0, 2'b00, 12'h340, 32'h0000_0000, 0);
  endtask

  task automatic test_clk_en_stall();
    run_single("rw_stall", 1'b0, 2'b01, 12'h340, 32'h0BAD_F00D, 5);
  endtask

  // Reset asserted while the write strobe is up: no write, no done.
  task automatic test_reset_mid();
    int wr0, pd0, dd0;
    wr0 = wr_cnt;
    pd0 = pl_done_cnt;
    dd0 = dbg_done_cnt;
    drive_req(1'b0, 1'b1, 2'b01, 12'h341, 32'h0000_0055);
    repeat (2) @(negedge clk_i);
    checks++;
    if (csr_we_o !== 1'b1) begin
      $display("FAIL rst_mid_in_wr: csr_we_o=%b need 1 before reset", csr_we_o);
      failures++;
    end
    reset_i = 1'b1;
    #1;
    checks++;
    if ({csr_access_o, csr_we_o, csr_addr_o, csr_wdata_o, rdata_o,
         pl_done_o, dbg_done_o, pl_illegal_o, dbg_illegal_o} !== '0) begin
      $display("FAIL rst_mid_outputs: access=%b we=%b addr=%h wdata=%h need all 0",
               csr_access_o, csr_we_o, csr_addr_o, csr_wdata_o);
      failures++;
    end
    drive_req(1'b0, 1'b0, 2'b00, '0, '0);
    repeat (2) @(negedge clk_i);
    reset_i = 1'b0;
    repeat (6) @(negedge clk_i);
    checks += 2;
    if (wr_cnt != wr0 || csr_mem[12'h341] !== ref_mem[12'h341]) begin
      $display("FAIL rst_mid_write: writes=%0d value=%h need 0 writes value %h",
               wr_cnt - wr0, csr_mem[12'h341], ref_mem[12'h341]);
      failures++;
    end
    if (pl_done_cnt != pd0 || dbg_done_cnt != dd0) begin
      $display("FAIL rst_mid_done: %0d/%0d done pulses need 0",
               pl_done_cnt - pd0, dbg_done_cnt - dd0);
      failures++;
    end
  endtask

  task automatic test_dbg_cfg();
`ifdef CSR_RMW_DEBUG_PORT_EN
    run_single("dbg_rc",  1'b1, 2'b11, 12'h305, 32'h0000_00F0, 0);
    run_single("dbg_rw",  1'b1, 2'b01, 12'hC10, 32'h0000_0001, 0);
`else
    int acc = 0;
    int dd0;
    dd0 = dbg_done_cnt;
    drive_req(1'b1, 1'b1, 2'b01, 12'h300, 32'hFFFF_FFFF);
    repeat (10) begin
      @(negedge clk_i);
      if (csr_access_o) acc++;
    end
    drive_req(1'b1, 1'b0, 2'b00, '0, '0);
    checks += 2;
    if (acc != 0) begin
      $display("FAIL dbg_ignored_access: %0d access cycles need 0", acc);
      failures++;
    end
    if (dbg_done_cnt != dd0 || csr_mem[12'h300] !== ref_mem[12'h300]) begin
      $display("FAIL dbg_ignored_effect: done=%0d csr=%h need 0 and %h",
               dbg_done_cnt - dd0, csr_mem[12'h300], ref_mem[12'h300]);
      failures++;
    end
    run_single("pl_after_dbg", 1'b0, 2'b00, 12'h300, 32'h0, 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) begin
      csr_mem[i] = '0;
      ref_mem[i] = '0;
    end
    csr_mem[12'h340] = 32'h0000_1234; ref_mem[12'h340] = 32'h0000_1234;
    csr_mem[12'h300] = 32'h0000_1888; ref_mem[12'h300] = 32'h0000_1888;
    csr_mem[12'h305] = 32'h0000_00FF; ref_mem[12'h305] = 32'h0000_00FF;
    csr_mem[12'hC00] = 32'hDEAD_BEEF; ref_mem[12'hC00] = 32'hDEAD_BEEF;
    test_reset();
    test_back_to_back();
    test_rmw_ops();
    test_clk_en_stall();
    test_reset_mid();
    test_dbg_cfg();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
